// File: rtl/exu_issue_ctrl.sv
// exu_issue_ctrl -- issue controller between the EXU decoder and the execute pipe.
//
// Holds one decoded instruction in an issue register and tracks pending
// register writes in a 32-entry busy scoreboard. A decoded instruction is
// stalled on RAW/WAW hazards against the scoreboard, or when MAX_INFLIGHT
// writes are already outstanding. Writebacks clear busy bits.
//
// Optional feature (macro EXU_WB_BYPASS_EN):
//   defined   - the hazard/capacity check sees the same-cycle writeback,
//               so a consumer issues in the writeback cycle.
//   undefined - the check uses registered busy_vec/inflight_cnt only,
//               so a consumer issues the cycle after writeback.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   flush               synchronous pipeline flush, clears all state
//   dec_*               decoded instruction in (valid/ready handshake)
//   iss_*               issue register out (valid/ready handshake)
//   wb_valid, wb_ldst   register writeback
//   busy_vec            scoreboard, bit r = write to xr pending
//   inflight_cnt        number of outstanding register writes

module exu_issue_ctrl #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [31:0]      dec_inst,
  input  logic [4:0]       dec_lsrc1,
  input  logic [4:0]       dec_lsrc2,
  input  logic [4:0]       dec_ldst,
  input  logic             dec_rs1_en,
  input  logic             dec_rs2_en,
  input  logic             dec_rd_en,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [31:0]      iss_inst,
  output logic [4:0]       iss_lsrc1,
  output logic [4:0]       iss_lsrc2,
  output logic [4:0]       iss_ldst,
  output logic             iss_rd_en,
  input  logic             wb_valid,
  input  logic [4:0]       wb_ldst,
  output logic [31:0]      busy_vec,
  output logic [CNT_W-1:0] inflight_cnt
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  logic             rd_eff;
  logic [31:0]      wb_mask;
  logic             wb_hit;
  logic [31:0]      busy_eff;
  logic [CNT_W-1:0] cnt_eff;
  logic             hazard;
  logic             accept;
  logic [31:0]      set_mask;
  logic [31:0]      busy_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    // x0 is never a real destination: no busy set, no count.
    rd_eff  = dec_rd_en && (dec_ldst != 5'd0);
    wb_mask = (wb_valid && (wb_ldst != 5'd0)) ? (32'd1 << wb_ldst) : '0;
    // Only a writeback to a register that is actually busy retires a write.
    wb_hit  = |(busy_vec & wb_mask);

`ifdef EXU_WB_BYPASS_EN
    busy_eff = busy_vec & ~wb_mask;
    cnt_eff  = inflight_cnt - CNT_W'(wb_hit);
`else
    busy_eff = busy_vec;
    cnt_eff  = inflight_cnt;
`endif

    hazard = (dec_rs1_en && busy_eff[dec_lsrc1]) ||
             (dec_rs2_en && busy_eff[dec_lsrc2]) ||
             (rd_eff && busy_eff[dec_ldst])      ||
             (rd_eff && (cnt_eff == MAX_CNT));

    dec_ready = !flush && (!iss_valid || iss_ready) && !hazard;
    accept    = dec_valid && dec_ready;

    set_mask = (accept && rd_eff) ? (32'd1 << dec_ldst) : '0;
    // Clear before set so a same-register set and writeback leaves busy=1.
    busy_nxt = (busy_vec & ~(wb_hit ? wb_mask : '0)) | set_mask;
    busy_nxt[0] = 1'b0;
    cnt_nxt  = inflight_cnt + CNT_W'(accept && rd_eff) - CNT_W'(wb_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec     <= '0;
      inflight_cnt <= '0;
    end else if (flush) begin
      busy_vec     <= '0;
      inflight_cnt <= '0;
    end else begin
      busy_vec     <= busy_nxt;
      inflight_cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid <= 1'b0;
      iss_inst  <= '0;
      iss_lsrc1 <= '0;
      iss_lsrc2 <= '0;
      iss_ldst  <= '0;
      iss_rd_en <= 1'b0;
    end else if (flush) begin
      iss_valid <= 1'b0;
    end else if (accept) begin
      iss_valid <= 1'b1;
      iss_inst  <= dec_inst;
      iss_lsrc1 <= dec_lsrc1;
      iss_lsrc2 <= dec_lsrc2;
      iss_ldst  <= dec_ldst;
      iss_rd_en <= rd_eff;
    end else if (iss_ready) begin
      iss_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exu_issue_ctrl.sv
module tb_exu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [4:0]  dec_lsrc1, dec_lsrc2, dec_ldst;
  logic        dec_rs1_en, dec_rs2_en, dec_rd_en;
  logic        iss_valid;
  logic        iss_ready;
  logic [31:0] iss_inst;
  logic [4:0]  iss_lsrc1, iss_lsrc2, iss_ldst;
  logic        iss_rd_en;
  logic        wb_valid;
  logic [4:0]  wb_ldst;
  logic [31:0] busy_vec;
  logic [2:0]  inflight_cnt;

  int checks = 0;
  int errors = 0;

  exu_issue_ctrl #(.MAX_INFLIGHT(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst),
    .dec_lsrc1(dec_lsrc1), .dec_lsrc2(dec_lsrc2), .dec_ldst(dec_ldst),
    .dec_rs1_en(dec_rs1_en), .dec_rs2_en(dec_rs2_en), .dec_rd_en(dec_rd_en),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_inst(iss_inst),
    .iss_lsrc1(iss_lsrc1), .iss_lsrc2(iss_lsrc2), .iss_ldst(iss_ldst),
    .iss_rd_en(iss_rd_en), .wb_valid(wb_valid), .wb_ldst(wb_ldst),
    .busy_vec(busy_vec), .inflight_cnt(inflight_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Step to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst,
                       input logic [4:0] s1, input logic e1,
                       input logic [4:0] s2, input logic e2,
                       input logic [4:0] d, input logic ed);
    dec_valid = v; dec_inst = inst;
    dec_lsrc1 = s1; dec_rs1_en = e1;
    dec_lsrc2 = s2; dec_rs2_en = e2;
    dec_ldst = d; dec_rd_en = ed;
  endtask

  task automatic wb(input logic v, input logic [4:0] r);
    wb_valid = v; wb_ldst = r;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; iss_ready = 1'b1;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    wb(1'b0, 5'd0);
    #1;
    chk("rst_iss_valid", {31'd0, iss_valid}, 32'd0);
    chk("rst_iss_inst", iss_inst, 32'd0);
    chk("rst_busy", busy_vec, 32'd0);
    chk("rst_cnt", {29'd0, inflight_cnt}, 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // Independent stream x1..x4
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'h100 + i, 5'd0, 1'b0, 5'd0, 1'b0, 5'(i), 1'b1);
      #1;
      chk("stream_ready", {31'd0, dec_ready}, 32'd1);
      cyc();
      chk("stream_iss_inst", iss_inst, 32'h100 + i);
    end
    chk("stream_iss_valid", {31'd0, iss_valid}, 32'd1);
    chk("stream_iss_ldst", {27'd0, iss_ldst}, 32'd4);
    chk("stream_busy", busy_vec, 32'h1E);
    chk("stream_cnt", {29'd0, inflight_cnt}, 32'd4);

    // Capacity: 5th writer to x5 stalls until wb x1
    drive(1'b1, 32'h105, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    #1;
    chk("cap_stall", {31'd0, dec_ready}, 32'd0);
    cyc();
    chk("cap_drained_iss", {31'd0, iss_valid}, 32'd0);
    chk("cap_cnt_held", {29'd0, inflight_cnt}, 32'd4);
    wb(1'b1, 5'd1);
    #1;
`ifdef EXU_WB_BYPASS_EN
    chk("cap_wb_ready", {31'd0, dec_ready}, 32'd1);
    cyc();
    wb(1'b0, 5'd0);
`else
    chk("cap_wb_ready", {31'd0, dec_ready}, 32'd0);
    cyc();
    wb(1'b0, 5'd0);
    chk("cap_wb_busy", busy_vec, 32'h1C);
    chk("cap_wb_cnt", {29'd0, inflight_cnt}, 32'd3);
    #1;
    chk("cap_after_ready", {31'd0, dec_ready}, 32'd1);
    cyc();
`endif
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("cap_iss_inst", iss_inst, 32'h105);
    chk("cap_busy", busy_vec, 32'h3C);
    chk("cap_cnt", {29'd0, inflight_cnt}, 32'd4);
    for (int r = 2; r <= 5; r++) begin
      wb(1'b1, 5'(r));
      cyc();
    end
    wb(1'b0, 5'd0);
    chk("drain_busy", busy_vec, 32'd0);
    chk("drain_cnt", {29'd0, inflight_cnt}, 32'd0);

    // RAW: producer x5, consumer reads x5
    drive(1'b1, 32'hA0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    cyc();
    drive(1'b1, 32'hB0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1);
    #1;
    chk("raw_stall", {31'd0, dec_ready}, 32'd0);
    cyc();
    chk("raw_stall_busy", busy_vec, 32'h20);
    wb(1'b1, 5'd5);
    #1;
`ifdef EXU_WB_BYPASS_EN
    chk("raw_wb_ready", {31'd0, dec_ready}, 32'd1);
    cyc();
    wb(1'b0, 5'd0);
`else
    chk("raw_wb_ready", {31'd0, dec_ready}, 32'd0);
    cyc();
    wb(1'b0, 5'd0);
    chk("raw_busy_clr", busy_vec, 32'd0);
    #1;
    chk("raw_after_ready", {31'd0, dec_ready}, 32'd1);
    cyc();
`endif
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("raw_iss_inst", iss_inst, 32'hB0);
    chk("raw_iss_lsrc1", {27'd0, iss_lsrc1}, 32'd5);
    chk("raw_busy", busy_vec, 32'h40);
    chk("raw_cnt", {29'd0, inflight_cnt}, 32'd1);
    wb(1'b1, 5'd6);
    cyc();
    wb(1'b0, 5'd0);
    chk("raw_final_cnt", {29'd0, inflight_cnt}, 32'd0);

    // Backpressure
    iss_ready = 1'b0;
    drive(1'b1, 32'hC0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    chk("bp_first_ready", {31'd0, dec_ready}, 32'd1);
    cyc();
    drive(1'b1, 32'hD0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready_low", {31'd0, dec_ready}, 32'd0);
      chk("bp_inst_stable", iss_inst, 32'hC0);
      chk("bp_valid_held", {31'd0, iss_valid}, 32'd1);
      cyc();
    end
    iss_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, dec_ready}, 32'd1);
    cyc();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("bp_b2b_inst", iss_inst, 32'hD0);
    chk("bp_b2b_valid", {31'd0, iss_valid}, 32'd1);
    cyc();
    chk("bp_drain_valid", {31'd0, iss_valid}, 32'd0);

    // x0 and WAW
    drive(1'b1, 32'hE0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    cyc();
    chk("x0_busy", busy_vec, 32'd0);
    chk("x0_cnt", {29'd0, inflight_cnt}, 32'd0);
    chk("x0_iss_rd_en", {31'd0, iss_rd_en}, 32'd0);
    drive(1'b1, 32'hE1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    cyc();
    chk("waw_first_busy", busy_vec, 32'h80);
    drive(1'b1, 32'hE2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    wb(1'b1, 5'd9);
    #1;
    chk("waw_stall", {31'd0, dec_ready}, 32'd0);
    cyc();
    chk("wb_nonbusy_cnt", {29'd0, inflight_cnt}, 32'd1);
    chk("wb_nonbusy_busy", busy_vec, 32'h80);
    wb(1'b1, 5'd7);
    #1;
`ifdef EXU_WB_BYPASS_EN
    chk("waw_wb_ready", {31'd0, dec_ready}, 32'd1);
    cyc();
    wb(1'b0, 5'd0);
`else
    chk("waw_wb_ready", {31'd0, dec_ready}, 32'd0);
    cyc();
    wb(1'b0, 5'd0);
    #1;
    chk("waw_after_ready", {31'd0, dec_ready}, 32'd1);
    cyc();
`endif
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("waw_iss_inst", iss_inst, 32'hE2);
    chk("waw_busy", busy_vec, 32'h80);
    chk("waw_cnt", {29'd0, inflight_cnt}, 32'd1);
    wb(1'b1, 5'd7);
    cyc();
    wb(1'b0, 5'd0);

    // Flush with x1..x3 pending and an instruction held
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 32'hF0 + i, 5'd0, 1'b0, 5'd0, 1'b0, 5'(i), 1'b1);
      cyc();
    end
    iss_ready = 1'b0;
    chk("pre_flush_busy", busy_vec, 32'h0E);
    chk("pre_flush_cnt", {29'd0, inflight_cnt}, 32'd3);
    flush = 1'b1;
    drive(1'b1, 32'hFF, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
    wb(1'b1, 5'd1);
    #1;
    chk("flush_ready", {31'd0, dec_ready}, 32'd0);
    cyc();
    flush = 1'b0;
    wb(1'b0, 5'd0);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("flush_iss_valid", {31'd0, iss_valid}, 32'd0);
    chk("flush_busy", busy_vec, 32'd0);
    chk("flush_cnt", {29'd0, inflight_cnt}, 32'd0);
    iss_ready = 1'b1;

    // Asynchronous reset mid-operation
    drive(1'b1, 32'h77, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
    cyc();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk("pre_rst_busy", busy_vec, 32'h08);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_iss_valid", {31'd0, iss_valid}, 32'd0);
    chk("arst_iss_inst", iss_inst, 32'd0);
    chk("arst_busy", busy_vec, 32'd0);
    chk("arst_cnt", {29'd0, inflight_cnt}, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
